// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift/rotate unit.
//   - op encodings for the five shift modes (values above OP_ROL are illegal)
//   - FSM state encoding, which the top also exposes for debug
//   - clog2 helper for deriving field widths from parameters
//   - op_legal helper used by the FSM to short-circuit illegal requests
package shift_pkg;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves value by amt (0..STEP) bits in the
// requested mode and reports the last bit that left the word.
//   value   in  WIDTH   word to shift
//   op      in  3       mode (SHR/SHRA/SHL/ROR/ROL); anything else passes through
//   amt     in  AMT_W   bits to shift this stage, 0..STEP
//   shifted out WIDTH   shifted word
//   carry   out 1       last bit shifted out (0 when amt is 0)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] shifted,
  output logic             carry
);

  // One guard bit below (right shifts) or above (left shifts) the word
  // catches the last bit to fall off, so carry needs no variable index.
  logic [WIDTH:0] ext_r;
  logic [WIDTH:0] ext_l;

  always_comb begin
    shifted = value;
    carry   = 1'b0;
    ext_r   = '0;
    ext_l   = '0;
    case (op)
      OP_SHR: begin
        ext_r   = {value, 1'b0} >> amt;
        shifted = ext_r[WIDTH:1];
        carry   = ext_r[0];
      end
      OP_SHRA: begin
        ext_r   = $signed({value, 1'b0}) >>> amt;
        shifted = ext_r[WIDTH:1];
        carry   = ext_r[0];
      end
      OP_SHL: begin
        ext_l   = {1'b0, value} << amt;
        shifted = ext_l[WIDTH-1:0];
        carry   = ext_l[WIDTH];
      end
      OP_ROR: begin
        // A shift by WIDTH yields 0, so amt == 0 leaves value unchanged.
        shifted = (value >> amt) | (value << (WIDTH - int'(amt)));
        carry   = (amt != '0) && shifted[WIDTH-1];
      end
      OP_ROL: begin
        shifted = (value << amt) | (value >> (WIDTH - int'(amt)));
        carry   = (amt != '0) && shifted[0];
      end
      default: begin
        shifted = value;
        carry   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: shifts STEP bits per clock until the
// requested count is consumed, then presents the result for one cycle.
//   clk        in  1      rising-edge clock
//   clr        in  1      asynchronous active-low reset
//   start      in  1      request, sampled in IDLE or DONE
//   op         in  3      mode: SHR, SHRA, SHL, ROR, ROL; 101-111 illegal
//   operand    in  WIDTH  value to shift
//   amount     in  WIDTH  shift count, only the low CNT_W bits are used
//   busy       out 1      high while shifting
//   done       out 1      one-cycle pulse, result/carry_out/op_err valid
//   result     out WIDTH  shifted value, held until the next done
//   carry_out  out 1      last bit shifted out
//   op_err     out 1      pulses with done for an illegal op
//   fsm_state  out 2      current FSM state (debug)
//
// Handshake: a request is taken on any rising edge where start=1 and the
// unit is not in SHIFT (IDLE or DONE); the unit then ignores start and all
// inputs until it raises done for exactly one cycle. A start during that
// done cycle is accepted, so operations can run back to back.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             op_err,
  output state_e           fsm_state
);

  localparam int CNT_W = clog2(WIDTH);
  localparam int AMT_W = clog2(STEP) + 1;
  localparam int CW1   = CNT_W + 1;
  // STEP may equal WIDTH, which does not fit in CNT_W bits.
  localparam logic [CW1-1:0] STEP_EXT = CW1'(STEP);

  state_e           state;
  state_e           state_next;

  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       op_q;
  logic             err_q;

  logic             accept;
  logic [CNT_W-1:0] count_in;
  logic             finish_now;
  logic [CW1-1:0]   rem_ext;
  logic [CW1-1:0]   step_ext;
  logic [CW1-1:0]   rem_left;
  logic [AMT_W-1:0] step_amt;
  logic             last_step;
  logic [WIDTH-1:0] step_value;
  logic             step_carry;
  logic             unused_bits;

  assign count_in    = amount[CNT_W-1:0];
  assign accept      = start && (state != ST_SHIFT);
  // Zero count and illegal ops skip SHIFT and report straight from the inputs.
  assign finish_now  = (count_in == '0) || !op_legal(op);
  assign unused_bits = ^{amount[WIDTH-1:CNT_W], rem_left[CNT_W]};

  // Per-edge step size: min(STEP, remaining).
  always_comb begin
    rem_ext   = {1'b0, remaining};
    step_ext  = (rem_ext > STEP_EXT) ? STEP_EXT : rem_ext;
    rem_left  = rem_ext - step_ext;
    step_amt  = step_ext[AMT_W-1:0];
    last_step = (rem_left == '0);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .value   (acc),
    .op      (op_q),
    .amt     (step_amt),
    .shifted (step_value),
    .carry   (step_carry)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = finish_now ? ST_DONE : ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_step) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc       <= '0;
      remaining <= '0;
      op_q      <= '0;
      err_q     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      acc       <= operand;
      remaining <= count_in;
      op_q      <= op;
      if (finish_now) begin
        result    <= operand;
        carry_out <= 1'b0;
        err_q     <= !op_legal(op);
      end
    end else if (state == ST_SHIFT) begin
      acc       <= step_value;
      remaining <= rem_left[CNT_W-1:0];
      if (last_step) begin
        result    <= step_value;
        carry_out <= step_carry;
        err_q     <= 1'b0;
      end
    end
  end

  assign busy      = (state == ST_SHIFT);
  assign done      = (state == ST_DONE);
  // err_q holds between operations; it is only visible during done.
  assign op_err    = done && err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: three instances (STEP 1, 4, 8) each with its own
// driver lane, a behavioural model, a per-lane expected queue and one
// per-cycle compare process.
module tb_seq_shift_unit;
  import shift_pkg::*;

  localparam int W  = 32;
  localparam int NL = 3;

  typedef struct {
    int             start_cyc;
    int             done_cyc;
    logic [W-1:0]   res;
    logic           carry;
    logic           err;
  } txn_t;

  logic           clk = 1'b0;
  logic           clr = 1'b0;
  logic           start_v   [NL];
  logic [2:0]     op_v      [NL];
  logic [W-1:0]   operand_v [NL];
  logic [W-1:0]   amount_v  [NL];
  logic           busy_v    [NL];
  logic           done_v    [NL];
  logic [W-1:0]   result_v  [NL];
  logic           carry_v   [NL];
  logic           err_v     [NL];
  state_e         state_v   [NL];

  txn_t           exp_q [NL][$];
  logic [W-1:0]   last_res   [NL];
  logic           last_carry [NL];

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  seq_shift_unit #(.WIDTH(W), .STEP(1)) u_s1 (
    .clk(clk), .clr(clr), .start(start_v[0]), .op(op_v[0]),
    .operand(operand_v[0]), .amount(amount_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .result(result_v[0]), .carry_out(carry_v[0]),
    .op_err(err_v[0]), .fsm_state(state_v[0])
  );
  seq_shift_unit #(.WIDTH(W), .STEP(4)) u_s4 (
    .clk(clk), .clr(clr), .start(start_v[1]), .op(op_v[1]),
    .operand(operand_v[1]), .amount(amount_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .result(result_v[1]), .carry_out(carry_v[1]),
    .op_err(err_v[1]), .fsm_state(state_v[1])
  );
  seq_shift_unit #(.WIDTH(W), .STEP(8)) u_s8 (
    .clk(clk), .clr(clr), .start(start_v[2]), .op(op_v[2]),
    .operand(operand_v[2]), .amount(amount_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .result(result_v[2]), .carry_out(carry_v[2]),
    .op_err(err_v[2]), .fsm_state(state_v[2])
  );

  // ---------------- model ----------------
  function automatic int lane_step(input int lane);
    return (lane == 0) ? 1 : ((lane == 1) ? 4 : 8);
  endfunction

  // Returns {op_err, carry_out, result}.
  function automatic logic [W+1:0] model(input logic [2:0] op,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] amount);
    int           c;
    logic [W-1:0] r;
    logic         cy;
    logic         err;
    c   = int'(amount[4:0]);
    r   = x;
    cy  = 1'b0;
    err = 1'b0;
    case (op)
      3'd0: begin r = x >> c; cy = (c != 0) ? x[c-1] : 1'b0; end
      3'd1: begin r = W'($signed(x) >>> c); cy = (c != 0) ? x[c-1] : 1'b0; end
      3'd2: begin r = x << c; cy = (c != 0) ? x[W-c] : 1'b0; end
      3'd3: begin
        r  = (c != 0) ? ((x >> c) | (x << (W - c))) : x;
        cy = (c != 0) ? r[W-1] : 1'b0;
      end
      3'd4: begin
        r  = (c != 0) ? ((x << c) | (x >> (W - c))) : x;
        cy = (c != 0) ? r[0] : 1'b0;
      end
      default: begin r = x; cy = 1'b0; err = 1'b1; end
    endcase
    return {err, cy, r};
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [W+1:0] act,
                       input logic [W+1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic check_lane(input int l);
    logic   exp_busy;
    logic   exp_done;
    state_e exp_state;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (!clr) begin
      check($sformatf("L%0d rst busy", l),   W'(busy_v[l]),  '0);
      check($sformatf("L%0d rst done", l),   W'(done_v[l]),  '0);
      check($sformatf("L%0d rst result", l), W'(result_v[l]), '0);
      check($sformatf("L%0d rst carry", l),  W'(carry_v[l]), '0);
      check($sformatf("L%0d rst err", l),    W'(err_v[l]),   '0);
      return;
    end
    if (exp_q[l].size() > 0 && exp_q[l][0].start_cyc <= cyc) begin
      exp_busy = (cyc < exp_q[l][0].done_cyc);
      exp_done = (cyc == exp_q[l][0].done_cyc);
    end
    exp_state = exp_done ? ST_DONE : (exp_busy ? ST_SHIFT : ST_IDLE);
    check($sformatf("L%0d busy", l),  W'(busy_v[l]), W'(exp_busy));
    check($sformatf("L%0d done", l),  W'(done_v[l]), W'(exp_done));
    check($sformatf("L%0d state", l), W'(state_v[l]), W'(exp_state));
    if (exp_done) begin
      check($sformatf("L%0d result", l), W'(result_v[l]), W'(exp_q[l][0].res));
      check($sformatf("L%0d carry", l),  W'(carry_v[l]),  W'(exp_q[l][0].carry));
      check($sformatf("L%0d op_err", l), W'(err_v[l]),    W'(exp_q[l][0].err));
      last_res[l]   = exp_q[l][0].res;
      last_carry[l] = exp_q[l][0].carry;
      void'(exp_q[l].pop_front());
    end else begin
      check($sformatf("L%0d held result", l), W'(result_v[l]), W'(last_res[l]));
      check($sformatf("L%0d held carry", l),  W'(carry_v[l]),  W'(last_carry[l]));
      check($sformatf("L%0d idle op_err", l), W'(err_v[l]),    '0);
    end
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) check_lane(l);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int lane, input logic [2:0] op,
                       input logic [W-1:0] x, input logic [W-1:0] amount);
    int           waited;
    int           c;
    int           n;
    logic [W+1:0] m;
    txn_t         t;
    waited = 0;
    while (!(exp_q[lane].size() == 0 || exp_q[lane][$].done_cyc <= cyc)) begin
      @(negedge clk);
      waited++;
      if (waited > 300) begin
        fail_now($sformatf("L%0d issue wait", lane));
        return;
      end
    end
    m = model(op, x, amount);
    c = int'(amount[4:0]);
    n = (m[W+1] || c == 0) ? 0 : (c + lane_step(lane) - 1) / lane_step(lane);
    t.start_cyc = cyc + 1;
    t.done_cyc  = cyc + 1 + n;
    t.res       = m[W-1:0];
    t.carry     = m[W];
    t.err       = m[W+1];
    exp_q[lane].push_back(t);
    start_v[lane]   = 1'b1;
    op_v[lane]      = op;
    operand_v[lane] = x;
    amount_v[lane]  = amount;
    @(posedge clk);
    #1;
    // Inputs are don't-care after the accepting edge.
    start_v[lane]   = 1'b0;
    op_v[lane]      = 3'($urandom_range(0, 7));
    operand_v[lane] = $urandom();
    amount_v[lane]  = $urandom();
  endtask

  // Pulse start with junk while the lane is shifting; all must be ignored.
  task automatic poke(input int lane, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (!(exp_q[lane].size() > 0 && exp_q[lane][$].start_cyc <= cyc &&
            cyc < exp_q[lane][$].done_cyc)) break;
      start_v[lane]   = 1'b1;
      op_v[lane]      = 3'($urandom_range(0, 7));
      operand_v[lane] = $urandom();
      amount_v[lane]  = $urandom();
      @(posedge clk);
      #1;
      start_v[lane] = 1'b0;
    end
  endtask

  // Counts cycles (and busy cycles) from the accepting edge up to done.
  task automatic measure(input int lane, output int ncyc, output int nbusy);
    ncyc  = 0;
    nbusy = 0;
    while (ncyc < 60) begin
      @(negedge clk);
      ncyc++;
      if (done_v[lane]) return;
      if (busy_v[lane]) nbusy++;
    end
    fail_now($sformatf("L%0d measure", lane));
  endtask

  task automatic rand_lane(input int lane, input int count);
    logic [2:0]   op;
    logic [W-1:0] amt;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op  = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(5, 7))
                                        : 3'($urandom_range(0, 4));
      amt = $urandom();
      if ($urandom_range(0, 7) == 0) amt[4:0] = 5'd0;
      issue(lane, op, $urandom(), amt);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nc;
    int nb;
    int guard;
    for (int l = 0; l < NL; l++) begin
      start_v[l]    = 1'b0;
      op_v[l]       = '0;
      operand_v[l]  = '0;
      amount_v[l]   = '0;
      last_res[l]   = '0;
      last_carry[l] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2 clr = 1'b1;
    @(negedge clk);

    // Model pins.
    check("model shra",  model(3'd1, 32'h8000FA92, 32'hA), {2'b01, 32'hFFE0003E});
    check("model rol",   model(3'd4, 32'h80000001, 32'd4), {2'b00, 32'h00000018});
    check("model ror",   model(3'd3, 32'h00000018, 32'd4), {2'b01, 32'h80000001});
    check("model shr",   model(3'd0, 32'hFFFFFFFF, 32'd20), {2'b01, 32'h00000FFF});
    check("model shl0",  model(3'd2, 32'h00001234, 32'd32), {2'b00, 32'h00001234});
    check("model shl31", model(3'd2, 32'h00000001, 32'd31), {2'b00, 32'h80000000});
    check("model ill",   model(3'd6, 32'hDEADBEEF, 32'd7), {2'b10, 32'hDEADBEEF});

    // STEP=1 SHRA: done 11 cycles after start, 10 busy cycles.
    issue(0, 3'd1, 32'h8000FA92, 32'hA);
    measure(0, nc, nb);
    check("shra latency", W'(nc), W'(11));
    check("shra busy",    W'(nb), W'(10));

    // STEP=4 ROL then back-to-back ROR in the done cycle.
    issue(1, 3'd4, 32'h80000001, 32'd4);
    measure(1, nc, nb);
    check("rol latency", W'(nc), W'(2));
    issue(1, 3'd3, 32'h00000018, 32'd4);
    measure(1, nc, nb);
    check("ror b2b latency", W'(nc), W'(2));

    // STEP=8 SHR by 20, then count 0.
    issue(2, 3'd0, 32'hFFFFFFFF, 32'd20);
    measure(2, nc, nb);
    check("shr latency", W'(nc), W'(4));
    check("shr busy",    W'(nb), W'(3));
    @(negedge clk);
    issue(2, 3'd2, 32'h00001234, 32'd32);
    measure(2, nc, nb);
    check("shl0 latency", W'(nc), W'(1));

    // Starts during SHIFT ignored; then an illegal op.
    @(negedge clk);
    issue(0, 3'd2, 32'h00000001, 32'd31);
    poke(0, 40);
    @(negedge clk);
    issue(0, 3'd6, 32'hDEADBEEF, 32'd7);
    measure(0, nc, nb);
    check("illegal latency", W'(nc), W'(1));

    // Asynchronous reset mid-SHIFT.
    @(negedge clk);
    issue(0, 3'd1, 32'h8000FA92, 32'd20);
    repeat (5) @(posedge clk);
    #2 clr = 1'b0;
    for (int l = 0; l < NL; l++) begin
      exp_q[l].delete();
      last_res[l]   = '0;
      last_carry[l] = 1'b0;
    end
    #1;
    check("async rst busy",   W'(busy_v[0]), '0);
    check("async rst done",   W'(done_v[0]), '0);
    check("async rst result", W'(result_v[0]), '0);
    check("async rst carry",  W'(carry_v[0]), '0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    @(negedge clk);
    issue(0, 3'd1, 32'h8000FA92, 32'hA);
    measure(0, nc, nb);
    check("post-rst latency", W'(nc), W'(11));

    // Randomized traffic on all lanes in parallel.
    @(negedge clk);
    fork
      rand_lane(0, 40);
      rand_lane(1, 60);
      rand_lane(2, 60);
    join

    guard = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) fail_now("drain");
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Multi-cycle, parametrised shift/rotate unit for the Mini SRC datapath ALU. It generalises the single-cycle SHRA path to five modes (SHR, SHRA, SHL, ROR, ROL), a configurable data width, and a configurable number of bits shifted per cycle. Control logic starts it with a start/done handshake. The result feeds the Z register input mux in place of the combinational shifter.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, >= 8.
STEP, 1, bits shifted per clock; power of two, 1..WIDTH.
CNT_W, clog2(WIDTH), derived width of the shift-count field; not overridable.

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only when the unit can accept (state IDLE or DONE).
op  in  3  mode: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 illegal.
operand  in  WIDTH  value to shift (the Y-side operand).
amount  in  WIDTH  shift count; only amount[CNT_W-1:0] is used (count mod WIDTH).
busy  out  1  high while in state SHIFT.
done  out  1  one-cycle pulse; result and flags are valid in this cycle.
result  out  WIDTH  shifted value; held from done until the next done.
carry_out  out  1  last bit shifted out (see Behaviour).
op_err  out  1  pulses with done when op is illegal.

Behaviour:
- Reset (clr=0, asynchronous): state IDLE; busy=0, done=0, op_err=0, carry_out=0, result=0; internal accumulator and counter cleared. Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 at edge E0:
  - Latch operand into the accumulator, count=amount[CNT_W-1:0], and op.
  - If count==0 or op is illegal: next state DONE. Otherwise next state SHIFT.
- IDLE or DONE with start=0: next state IDLE.
- SHIFT: each edge shifts the accumulator by s=min(STEP, remaining) in the latched mode and decrements remaining by s.
  - When remaining reaches 0, next state DONE.
  - N=ceil(count/STEP) shift edges are needed, so done is high in the cycle after edge E0+N.
  - For count==0, done is high in the cycle after E0.
- start during SHIFT is ignored; there is no queueing. Inputs are ignored after E0.
- DONE lasts exactly one cycle with done=1. A start in that cycle is accepted (back-to-back operation).
- result and carry_out register on entry to DONE and hold until the next entry to DONE.
- Fill rules:
  - SHR fills with 0 at the MSB.
  - SHRA replicates the operand MSB.
  - SHL fills with 0 at the LSB.
  - ROR/ROL wrap the bits around.
- carry_out:
  - SHR/SHRA: operand[count-1].
  - SHL: operand[WIDTH-count].
  - ROR: result MSB. ROL: result LSB.
  - count==0: 0.
  - The value is independent of STEP.
- Illegal op: result=operand, carry_out=0, op_err=1 in the DONE cycle; op_err=0 otherwise.

Decomposition:
- Package shift_pkg: op encodings (SHR, SHRA, SHL, ROR, ROL) as localparams/typedef, the state encoding, and a clog2 function.
- Sub-module shift_step: combinational, shifts a WIDTH value by 0..STEP bits per mode and returns the bits shifted out. It is instantiated once.
- The top module holds the FSM, counter, accumulator and output registers.

Test Plan:
- WIDTH=32, STEP=1: SHRA operand 0x8000FA92, amount 0xA -> result 0xFFE0003E, carry_out=1, done exactly 11 cycles after the start edge, busy high for 10 cycles.
- STEP=4: ROL 0x80000001 by 4 -> result 0x00000018, carry_out=0, done 2 cycles after start. Then ROR 0x00000018 by 4 issued in the done cycle -> 0x80000001, carry_out=1.
- STEP=8: SHR 0xFFFFFFFF by 20 -> 0x00000FFF, carry_out=1, 3 busy cycles. SHL 0x00001234 by 32 (count 0) -> 0x00001234, carry_out=0, done 1 cycle after start.
- Start pulses held during SHIFT of SHL 0x1 by 31 (STEP=1) -> ignored; single done with result 0x80000000. Op 110 -> op_err=1, result=operand.
- clr driven low mid-SHIFT -> busy, done, result, carry_out go to 0 immediately with no done pulse. After release, a new SHRA 0x8000FA92 by 0xA completes normally.
